// File: rtl/matrix_scan_pkg.sv
// Shared constants, scan state type and column-to-image mapping for the
// LED matrix column scanner.
package matrix_scan_pkg;

    localparam int NUM_ROWS          = 7;
    localparam int NUM_COLUMNS       = 5;
    localparam int NUM_IMAGE_COLUMNS = 3;
    localparam int COL_W             = $clog2(NUM_COLUMNS);

    localparam logic [NUM_ROWS-1:0] ROWS_OFF = 7'h7F;

    // Physical columns 1..3 carry image columns 2..0; columns 0 and 4 stay dark.
    localparam int FIRST_IMAGE_COL = 1;
    localparam int LAST_IMAGE_COL  = 3;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic logic column_has_image(input logic [COL_W-1:0] col);
        return (int'(col) >= FIRST_IMAGE_COL) && (int'(col) <= LAST_IMAGE_COL);
    endfunction

    function automatic logic [1:0] column_image_index(input logic [COL_W-1:0] col);
        return 2'(LAST_IMAGE_COL - int'(col));
    endfunction

endpackage

// File: rtl/matrix_frame_counter.sv
// Counts frame boundaries against MODE_FRAMES and owns the display_mode
// toggle register that selects the upstream image.
module matrix_frame_counter #(
    parameter int MODE_FRAMES = 500,
    parameter int CNT_W       = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic frame_tick,
    output logic display_mode
);

    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             mode_q, mode_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        if (frame_tick) begin
            if (frame_cnt_q == CNT_W'(MODE_FRAMES - 1)) begin
                frame_cnt_d = '0;
                mode_d      = ~mode_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            mode_q      <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
        end
    end

    assign display_mode = mode_q;

endmodule

// File: rtl/matrix_column_scanner.sv
// Time-multiplexes three image columns onto a 7x5 LED matrix with blanking.
// Optional MATRIX_LAMP_TEST_EN adds a lamp_test input forcing all rows on.
module matrix_column_scanner
    import matrix_scan_pkg::*;
#(
    parameter int COLUMN_HOLD  = 1000,
    parameter int BLANK_CYCLES = 8,
    parameter int MODE_FRAMES  = 500
) (
    input  logic                   clock,
    input  logic                   reset_n,
`ifdef MATRIX_LAMP_TEST_EN
    input  logic                   lamp_test,
`endif
    input  logic [NUM_ROWS-1:0]    column_2,
    input  logic [NUM_ROWS-1:0]    column_1,
    input  logic [NUM_ROWS-1:0]    column_0,
    output logic [NUM_COLUMNS-1:0] matrix_columns,
    output logic [NUM_ROWS-1:0]    matrix_rows,
    output logic                   display_mode,
    output logic                   frame_done
);

    localparam int MAX_BH    = (BLANK_CYCLES > COLUMN_HOLD) ? BLANK_CYCLES : COLUMN_HOLD;
    localparam int MAX_COUNT = (MAX_BH > MODE_FRAMES) ? MAX_BH : MODE_FRAMES;
    localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    scan_state_t                                   state_q, state_d;
    logic [CNT_W-1:0]                              cycle_cnt_q, cycle_cnt_d;
    logic [COL_W-1:0]                              col_q, col_d;
    logic [NUM_IMAGE_COLUMNS-1:0][NUM_ROWS-1:0]    shadow_q, shadow_d;
    logic [NUM_COLUMNS-1:0]                        columns_q, columns_d;
    logic [NUM_ROWS-1:0]                           rows_q, rows_d;
    logic                                          frame_done_q, frame_done_d;
    logic                                          frame_tick;

    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        col_d        = col_q;
        shadow_d     = shadow_q;
        frame_tick   = 1'b0;

        case (state_q)
            BLANK: begin
                if (cycle_cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d     = DRIVE;
                    cycle_cnt_d = '0;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            DRIVE: begin
                if (cycle_cnt_q == CNT_W'(COLUMN_HOLD - 1)) begin
                    state_d     = BLANK;
                    cycle_cnt_d = '0;
                    if (col_q == COL_W'(NUM_COLUMNS - 1)) begin
                        // Frame boundary: latch the next image so it never tears mid-frame.
                        col_d      = '0;
                        frame_tick = 1'b1;
                        shadow_d   = {column_2, column_1, column_0};
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = BLANK;
                cycle_cnt_d = '0;
            end
        endcase

        frame_done_d = frame_tick;

        // Outputs are derived from the next state so the registered drive lines up with it.
        columns_d = '0;
        rows_d    = ROWS_OFF;
        if (state_d == DRIVE) begin
            columns_d = {{(NUM_COLUMNS-1){1'b0}}, 1'b1} << col_d;
`ifdef MATRIX_LAMP_TEST_EN
            if (lamp_test) begin
                rows_d = '0;
            end else if (column_has_image(col_d)) begin
                rows_d = ~shadow_q[column_image_index(col_d)];
            end
`else
            if (column_has_image(col_d)) begin
                rows_d = ~shadow_q[column_image_index(col_d)];
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BLANK;
            cycle_cnt_q  <= '0;
            col_q        <= '0;
            shadow_q     <= '0;
            columns_q    <= '0;
            rows_q       <= ROWS_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            col_q        <= col_d;
            shadow_q     <= shadow_d;
            columns_q    <= columns_d;
            rows_q       <= rows_d;
            frame_done_q <= frame_done_d;
        end
    end

    matrix_frame_counter #(
        .MODE_FRAMES (MODE_FRAMES),
        .CNT_W       (CNT_W)
    ) u_frame_counter (
        .clock        (clock),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .display_mode (display_mode)
    );

    assign matrix_columns = columns_q;
    assign matrix_rows    = rows_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Scoreboard bench: a cycle-index reference model queues the expected outputs
// of every scan cycle; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_matrix_column_scanner;

    localparam int CH    = 4;
    localparam int BC    = 2;
    localparam int MF    = 2;
    localparam int SEG   = BC + CH;
    localparam int FRAME = 5 * SEG;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] column_2 = '0, column_1 = '0, column_0 = '0;
`ifdef MATRIX_LAMP_TEST_EN
    logic       lamp_test = 1'b0;
`endif
    logic [4:0] matrix_columns, cols1;
    logic [6:0] matrix_rows, rows1;
    logic       display_mode, mode1, frame_done, fd1;

    always #5 clock = ~clock;

    matrix_column_scanner #(.COLUMN_HOLD(CH), .BLANK_CYCLES(BC), .MODE_FRAMES(MF)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
`ifdef MATRIX_LAMP_TEST_EN
        .lamp_test      (lamp_test),
`endif
        .column_2       (column_2),
        .column_1       (column_1),
        .column_0       (column_0),
        .matrix_columns (matrix_columns),
        .matrix_rows    (matrix_rows),
        .display_mode   (display_mode),
        .frame_done     (frame_done)
    );

    matrix_column_scanner #(.COLUMN_HOLD(CH), .BLANK_CYCLES(BC), .MODE_FRAMES(1)) dut_m1 (
        .clock          (clock),
        .reset_n        (reset_n),
`ifdef MATRIX_LAMP_TEST_EN
        .lamp_test      (lamp_test),
`endif
        .column_2       (column_2),
        .column_1       (column_1),
        .column_0       (column_0),
        .matrix_columns (cols1),
        .matrix_rows    (rows1),
        .display_mode   (mode1),
        .frame_done     (fd1)
    );

    typedef struct packed {
        int         t;
        logic [4:0] cols;
        logic [6:0] rows;
        logic       mode;
        logic       mode1;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushes   = 0;
    int   pops     = 0;

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, t, act, req);
        end
    endtask

    // Expected outputs for cycle t after reset release, from frame arithmetic.
    function automatic exp_t model(input int t, input logic [2:0][6:0] img, input logic lamp);
        exp_t e;
        int   f     = t / FRAME;
        int   p     = t % FRAME;
        int   seg   = p / SEG;
        bit   drive = (p % SEG) >= BC;
        e.t    = t;
        e.cols = drive ? 5'(1 << seg) : 5'd0;
        e.rows = 7'h7F;
        if (drive) begin
            if (lamp)
                e.rows = 7'h00;
            else if (seg >= 1 && seg <= 3)
                e.rows = ~img[3 - seg];
        end
        e.fd    = (t > 0) && (p == 0);
        e.mode  = ((f / MF) % 2) == 1;
        e.mode1 = (f % 2) == 1;
        return e;
    endfunction

    // Monitor: compares every cycle the scoreboard has an expectation for.
    exp_t e_mon;
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                pops++;
                chk("columns",      e_mon.t, 32'(matrix_columns), 32'(e_mon.cols));
                chk("rows",         e_mon.t, 32'(matrix_rows),    32'(e_mon.rows));
                chk("display_mode", e_mon.t, 32'(display_mode),   32'(e_mon.mode));
                chk("frame_done",   e_mon.t, 32'(frame_done),     32'(e_mon.fd));
                chk("m1_columns",   e_mon.t, 32'(cols1),          32'(e_mon.cols));
                chk("m1_rows",      e_mon.t, 32'(rows1),          32'(e_mon.rows));
                chk("m1_mode",      e_mon.t, 32'(mode1),          32'(e_mon.mode1));
                chk("m1_frame_done",e_mon.t, 32'(fd1),            32'(e_mon.fd));
                if (e_mon.fd)
                    $display("frame boundary cycle=%0d display_mode=%0b m1_mode=%0b rows=%h",
                             e_mon.t, display_mode, mode1, matrix_rows);
            end
        end
    end

    int               t;
    logic [2:0][6:0]  img_cur;
    logic             lamp_edge;

    function automatic logic lamp_now();
`ifdef MATRIX_LAMP_TEST_EN
        return lamp_test;
`else
        return 1'b0;
`endif
    endfunction

    // Inputs for clock edge e: directed image sequence first, then random.
    task automatic drive_stim(input int e);
        if (e <= 75) begin
            column_2 = 7'h55; column_1 = 7'h2A; column_0 = 7'h7F;
        end else if (e < 120) begin
            column_2 = 7'h55; column_1 = 7'h01; column_0 = 7'h7F;
        end else begin
            column_2 = 7'($urandom); column_1 = 7'($urandom); column_0 = 7'($urandom);
        end
`ifdef MATRIX_LAMP_TEST_EN
        if (e >= 150 && e < 240)
            lamp_test = 1'b1;
        else if (e >= 300)
            lamp_test = ($urandom_range(0, 3) == 0);
        else
            lamp_test = 1'b0;
`endif
    endtask

    task automatic push_cycle();
        if (t > 0 && (t % FRAME) == 0)
            img_cur = {column_2, column_1, column_0};
        lamp_edge = lamp_now();
        exp_q.push_back(model(t, img_cur, lamp_edge));
        pushes++;
    endtask

    task automatic run_phase(input int n);
        @(posedge clock);
        #2 reset_n = 1'b1;
        t       = 0;
        img_cur = '0;
        push_cycle();
        drive_stim(1);
        while (t < n) begin
            @(posedge clock);
            #1;
            t++;
            push_cycle();
            drive_stim(t + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_stim(0);
        repeat (3) begin
            @(negedge clock);
            chk("reset_columns", -1, 32'(matrix_columns), 32'h00);
            chk("reset_rows",    -1, 32'(matrix_rows),    32'h7F);
            chk("reset_mode",    -1, 32'(display_mode),   32'h0);
            chk("reset_fd",      -1, 32'(frame_done),     32'h0);
        end

        run_phase(665);

        // Step without expectations into a DRIVE cycle, then reset with no clock edge.
        for (int k = 0; k < SEG; k++) begin
            @(posedge clock);
            #1;
            t++;
            if (((t % FRAME) % SEG) >= BC) break;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("async_columns", t, 32'(matrix_columns), 32'h00);
        chk("async_rows",    t, 32'(matrix_rows),    32'h7F);
        chk("async_mode",    t, 32'(display_mode),   32'h0);
        chk("async_fd",      t, 32'(frame_done),     32'h0);
        chk("async_m1_cols", t, 32'(cols1),          32'h00);
        chk("async_m1_mode", t, 32'(mode1),          32'h0);
        repeat (2) @(negedge clock);

        run_phase(200);

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", t, 32'(exp_q.size()), 32'd0);
        chk("scoreboard_pops",    t, 32'(pops),         32'(pushes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
